adc_seq: RTL and testbench

//  Top-level sequencer for the adc block: runs the fs_*/fd_* handshakes in order CHECK -> CONF -> {READ -> FIFO} per sample.

---
 rtl/adc_pkg.sv | 39 +++
 rtl/adc_seq_tick.sv | 47 ++++
 rtl/adc_seq.sv | 151 +++++++++++++++
 tb/tb_adc_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the adc sequencer: state codes, default timing constants
// and a helper that classifies handshake states.
package adc_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CHK    = 4'd1;
  localparam logic [3:0] S_CHK_D  = 4'd2;
  localparam logic [3:0] S_CONF   = 4'd3;
  localparam logic [3:0] S_CONF_D = 4'd4;
  localparam logic [3:0] S_WAIT   = 4'd5;
  localparam logic [3:0] S_RD     = 4'd6;
  localparam logic [3:0] S_RD_D   = 4'd7;
  localparam logic [3:0] S_FF     = 4'd8;
  localparam logic [3:0] S_FF_D   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd15;

  localparam int TICK_BASE_DEF = 250;
  localparam int WDOG_DEF      = 65535;

  typedef enum logic [3:0] {
    ST_IDLE   = S_IDLE,
    ST_CHK    = S_CHK,
    ST_CHK_D  = S_CHK_D,
    ST_CONF   = S_CONF,
    ST_CONF_D = S_CONF_D,
    ST_WAIT   = S_WAIT,
    ST_RD     = S_RD,
    ST_RD_D   = S_RD_D,
    ST_FF     = S_FF,
    ST_FF_D   = S_FF_D,
    ST_HALT   = S_HALT
  } state_e;

  // Handshake states are the only ones guarded by the watchdog.
  function automatic logic is_hs(input state_e s);
    return !(s inside {ST_IDLE, ST_WAIT, ST_HALT});
  endfunction

endpackage

// File: rtl/adc_seq_tick.sv
// Sample-period divider: down-counter reloaded to (smpr+1)*TICK_BASE-1,
// emits a one-cycle registered tick at each terminal count.
module adc_seq_tick
  import adc_pkg::*;
#(
  parameter int TICK_BASE = TICK_BASE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] smpr_i,
  output logic       tick_o
);

  // Wide enough for 256*TICK_BASE so the reload product is never truncated.
  localparam int PW = 9 + $clog2(TICK_BASE + 1);

  logic [PW-1:0] cnt_q, cnt_d, reload;
  logic          tick_q, tick_d;

  always_comb begin
    reload = (PW'(smpr_i) + PW'(1)) * PW'(TICK_BASE) - PW'(1);
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!en_i) begin
      cnt_d = reload;
    end else if (cnt_q == '0) begin
      cnt_d  = reload;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/adc_seq.sv
// adc sequencer: CHECK -> CONF -> {READ -> FIFO} per sample tick, with a
// per-phase watchdog, overrun counting and a sticky error/HALT on timeout.
module adc_seq
  import adc_pkg::*;
#(
  parameter int TICK_BASE = TICK_BASE_DEF,
  parameter int WDOG      = WDOG_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             conf_req,
  input  logic [7:0]       dev_smpr,
  input  logic             fifoa_full,
  input  logic             fd_check,
  input  logic             fd_conf,
  input  logic             fd_read,
  input  logic             fd_fifo,
  output logic             fs_check,
  output logic             fs_conf,
  output logic             fs_read,
  output logic             fs_fifo,
  output logic             busy,
  output logic             err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       ovr_cnt
);

  localparam int WW = $clog2(WDOG + 1);

  state_e           state_q, state_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [3:0]       fs_q, fs_d;
  logic             err_q, err_d;
  logic             conf_pend_q, conf_pend_d;
  logic             chk_done_q, chk_done_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [7:0]       ovr_q, ovr_d;
  logic             ovr_inc;
  logic             tick, tick_en;

  assign tick_en = !(state_q inside {ST_IDLE, ST_HALT});

  adc_seq_tick #(.TICK_BASE(TICK_BASE)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (tick_en),
    .smpr_i (dev_smpr),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    wdog_d      = '0;
    err_d       = err_q;
    conf_pend_d = conf_pend_q | conf_req;
    chk_done_d  = chk_done_q;
    frame_d     = frame_q;
    ovr_inc     = tick && is_hs(state_q);
    // Leaving X requires fd seen high while our own fs is up, so a stale fd
    // left over from before a reset cannot complete the phase.
    unique case (state_q)
      ST_IDLE: if (run) begin
        if (!chk_done_q) begin
          state_d    = ST_CHK;
          chk_done_d = 1'b1;
        end else if (conf_pend_d) state_d = ST_CONF;
        else                      state_d = ST_WAIT;
      end
      ST_CHK:    if (fd_check && fs_q[0]) state_d = ST_CHK_D;
      ST_CHK_D:  if (!fd_check) state_d = ST_CONF;
      ST_CONF:   if (fd_conf && fs_q[1]) state_d = ST_CONF_D;
      ST_CONF_D: if (!fd_conf) begin
        state_d     = ST_WAIT;
        conf_pend_d = conf_req;
      end
      ST_WAIT: begin
        if (conf_pend_d) begin
          state_d = ST_CONF;
          ovr_inc = tick;
        end else if (!run) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (fifoa_full) ovr_inc = 1'b1;
          else            state_d = ST_RD;
        end
      end
      ST_RD:   if (fd_read && fs_q[2]) state_d = ST_RD_D;
      ST_RD_D: if (!fd_read) state_d = ST_FF;
      ST_FF:   if (fd_fifo && fs_q[3]) state_d = ST_FF_D;
      ST_FF_D: if (!fd_fifo) begin
        frame_d = frame_q + CNT_W'(1);
        state_d = run ? ST_WAIT : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // A completing handshake changes state_d first, so fd wins over expiry.
    if (is_hs(state_q) && (state_d == state_q)) begin
      if (wdog_q == WW'(WDOG - 1)) begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + WW'(1);
      end
    end

    fs_d[0] = (state_q == ST_CHK)  && (state_d == ST_CHK)  && !fd_check;
    fs_d[1] = (state_q == ST_CONF) && (state_d == ST_CONF) && !fd_conf;
    fs_d[2] = (state_q == ST_RD)   && (state_d == ST_RD)   && !fd_read;
    fs_d[3] = (state_q == ST_FF)   && (state_d == ST_FF)   && !fd_fifo;

    ovr_d = (ovr_inc && (ovr_q != 8'hFF)) ? ovr_q + 8'd1 : ovr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wdog_q      <= '0;
      fs_q        <= '0;
      err_q       <= 1'b0;
      conf_pend_q <= 1'b1;
      chk_done_q  <= 1'b0;
      frame_q     <= '0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      fs_q        <= fs_d;
      err_q       <= err_d;
      conf_pend_q <= conf_pend_d;
      chk_done_q  <= chk_done_d;
      frame_q     <= frame_d;
      ovr_q       <= ovr_d;
    end
  end

  assign fs_check  = fs_q[0];
  assign fs_conf   = fs_q[1];
  assign fs_read   = fs_q[2];
  assign fs_fifo   = fs_q[3];
  assign busy      = !(state_q inside {ST_IDLE, ST_WAIT});
  assign err       = err_q;
  assign state     = state_q;
  assign frame_cnt = frame_q;
  assign ovr_cnt   = ovr_q;

endmodule

// File: tb/tb_adc_seq.sv
// Directed bench for adc_seq with a behavioural adc responder that echoes
// fs_* on fd_* with programmable rise delay and a fixed 3-cycle fall delay.
module tb_adc_seq;

  logic        clk = 1'b0;
  logic        rst, run, conf_req, fifoa_full;
  logic [7:0]  dev_smpr;
  logic [3:0]  fd_bus = '0;
  logic [3:0]  rsp_en = '1;
  int          dly[4] = '{3, 3, 3, 3};
  int          hi[4]  = '{0, 0, 0, 0};
  int          lo[4]  = '{0, 0, 0, 0};
  logic        fs_check, fs_conf, fs_read, fs_fifo, busy, err;
  logic [3:0]  state;
  logic [15:0] frame_cnt;
  logic [7:0]  ovr_cnt;
  logic [3:0]  fs_bus;

  int n_chk = 0, n_err = 0, cyc = 0;
  int oh_err = 0, hs_err = 0, chk_rises = 0;
  logic [3:0] fs_prev = '0;

  typedef struct {
    logic [7:0] smpr;
    int         period;
  } prd_vec_t;
  prd_vec_t vecs[4];

  adc_seq #(.TICK_BASE(10), .WDOG(100), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .conf_req   (conf_req),
    .dev_smpr   (dev_smpr),
    .fifoa_full (fifoa_full),
    .fd_check   (fd_bus[0]),
    .fd_conf    (fd_bus[1]),
    .fd_read    (fd_bus[2]),
    .fd_fifo    (fd_bus[3]),
    .fs_check   (fs_check),
    .fs_conf    (fs_conf),
    .fs_read    (fs_read),
    .fs_fifo    (fs_fifo),
    .busy       (busy),
    .err        (err),
    .state      (state),
    .frame_cnt  (frame_cnt),
    .ovr_cnt    (ovr_cnt)
  );

  assign fs_bus = {fs_fifo, fs_read, fs_conf, fs_check};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (fs_bus[i] && rsp_en[i]) begin
        lo[i] = 0;
        if (hi[i] < 1000) hi[i]++;
        if (hi[i] >= dly[i]) fd_bus[i] = 1'b1;
      end else begin
        hi[i] = 0;
        if (fd_bus[i]) begin
          lo[i]++;
          if (lo[i] >= 3) begin
            fd_bus[i] = 1'b0;
            lo[i] = 0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if ($countones(fs_bus) > 1) oh_err++;
    if ((fs_bus & ~fs_prev & fd_bus) != 4'b0) hs_err++;
    if (fs_bus[0] && !fs_prev[0]) chk_rises++;
    fs_prev = fs_bus;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic wait_rise(input int sel, input int maxc, input string nm, output int t);
    logic prev;
    prev = fs_bus[sel];
    t = -1;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (fs_bus[sel] && !prev) begin
        t = cyc;
        break;
      end
      prev = fs_bus[sel];
    end
    if (t < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got no rising edge in %0d cycles, required one", nm, maxc);
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input int maxc, input string nm, output int t);
    t = -1;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (state == st) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got state %0d after %0d cycles, required %0d", nm, state, maxc, st);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0, t1, t2, r, rn, r1, r2, tc, th, f0, ovr0, cnt;
    logic prev;
    vecs[0] = '{smpr: 8'd3, period: 40};
    vecs[1] = '{smpr: 8'd1, period: 20};
    vecs[2] = '{smpr: 8'd5, period: 60};
    vecs[3] = '{smpr: 8'd2, period: 30};

    rst = 1'b0; run = 1'b0; conf_req = 1'b0; fifoa_full = 1'b0; dev_smpr = 8'd3;
    repeat (3) @(negedge clk);
    check("rst_fs", int'(fs_bus), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_state", int'(state), 0);
    check("rst_frame", int'(frame_cnt), 0);
    check("rst_ovr", int'(ovr_cnt), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_hold_run0", int'(state), 0);

    // Bring-up: CHECK then CONF then WAIT
    run = 1'b1;
    wait_rise(0, 20, "bring_fs_check", t0);
    wait_rise(1, 40, "bring_fs_conf", t1);
    check("bring_order", int'(t1 > t0), 1);
    wait_state(4'd5, 40, "bring_wait", t2);
    check("bring_busy_wait", int'(busy), 0);

    // Periodic reads at 40 cycles, five frames
    wait_rise(2, 60, "per_first", r);
    for (int k = 0; k < 4; k++) begin
      wait_rise(2, 60, "per_next", rn);
      check("per_period", rn - r, 40);
      r = rn;
    end
    repeat (20) @(negedge clk);
    check("per_frame5", int'(frame_cnt), 5);
    check("per_ovr0", int'(ovr_cnt), 0);

    // Period table across sample-rate codes
    for (int v = 0; v < 4; v++) begin
      dev_smpr = vecs[v].smpr;
      wait_rise(2, 100, "tbl_settle1", r);
      wait_rise(2, 100, "tbl_settle2", r);
      wait_rise(2, 100, "tbl_meas", rn);
      check($sformatf("tbl_period_smpr%0d", vecs[v].smpr), rn - r, vecs[v].period);
    end
    dev_smpr = 8'd3;
    wait_rise(2, 100, "restore1", r);
    wait_rise(2, 100, "restore2", r);

    // FIFO full for three ticks
    wait_rise(2, 100, "full_start", r);
    ovr0 = ovr_cnt;
    fifoa_full = 1'b1;
    cnt = 0;
    prev = fs_read;
    while (cyc < r + 125) begin
      @(negedge clk);
      if (fs_read && !prev) cnt++;
      prev = fs_read;
    end
    check("full_no_read", cnt, 0);
    check("full_ovr3", int'(ovr_cnt) - ovr0, 3);
    check("full_state_wait", int'(state), 5);
    fifoa_full = 1'b0;
    wait_rise(2, 60, "full_resume", rn);
    check("full_resume_time", rn - r, 160);

    // conf_req during RD: frame completes, CONF precedes next read
    r = rn;
    f0 = frame_cnt;
    conf_req = 1'b1;
    @(negedge clk);
    conf_req = 1'b0;
    wait_rise(1, 40, "crd_fs_conf", tc);
    check("crd_frame_done", int'(frame_cnt) - f0, 1);
    check("crd_conf_first", int'(tc < r + 40), 1);
    wait_rise(2, 60, "crd_read", rn);
    check("crd_read_time", rn - r, 40);

    // conf_req coincident with the tick in WAIT
    r = rn;
    ovr0 = ovr_cnt;
    while (cyc < r + 38) @(negedge clk);
    conf_req = 1'b1;
    @(negedge clk);
    conf_req = 1'b0;
    wait_rise(1, 10, "ctk_fs_conf", tc);
    check("ctk_conf_time", tc - r, 40);
    check("ctk_ovr_inc", int'(ovr_cnt) - ovr0, 1);
    wait_rise(2, 90, "ctk_read", rn);
    check("ctk_read_time", rn - r, 80);

    // Overrun: slow fd_read
    r = rn;
    dly[2] = 60;
    ovr0 = ovr_cnt;
    f0 = frame_cnt;
    wait_rise(2, 100, "ovr_r1", r1);
    check("ovr_period1", r1 - r, 80);
    wait_rise(2, 100, "ovr_r2", r2);
    check("ovr_period2", r2 - r1, 80);
    check("ovr_count2", int'(ovr_cnt) - ovr0, 2);
    check("ovr_frames2", int'(frame_cnt) - f0, 2);
    dly[2] = 3;

    // Timeout in CONF
    wait_rise(2, 100, "to_read", r);
    rsp_en[1] = 1'b0;
    conf_req = 1'b1;
    @(negedge clk);
    conf_req = 1'b0;
    wait_rise(1, 40, "to_fs_conf", tc);
    wait_state(4'd15, 150, "to_halt", th);
    check("to_cycles", th - (tc - 1), 100);
    check("to_fs_conf_low", int'(fs_conf), 0);
    check("to_err", int'(err), 1);
    repeat (10) @(negedge clk);
    check("to_halt_stays", int'(state), 15);
    check("to_fs_all_low", int'(fs_bus), 0);
    check("chk_once", chk_rises, 1);
    check("onehot_fs", oh_err, 0);
    check("no_raise_fd_high", hs_err, 0);

    // Reset out of HALT, then asynchronous reset mid-RD
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rsp_en = '1;
    wait_rise(0, 20, "re_fs_check", t0);
    wait_rise(2, 100, "re_read", r);
    #2;
    check("mid_rd_active", int'(fs_read), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_fs", int'(fs_bus), 0);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_frame", int'(frame_cnt), 0);
    check("mid_rst_ovr", int'(ovr_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
